gpr_read_issue: RTL and testbench

//  Read/issue stage: consumer side of the register-file write path. Takes a decoded instruction

---
 rtl/gpr_read_issue_pkg.sv | 30 +++
 rtl/gpr_read_issue_sb_bitmap.sv | 60 ++++++
 rtl/gpr_read_issue.sv | 167 ++++++++++++++++
 tb/tb_gpr_read_issue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_read_issue_pkg.sv
// Shared constants and helpers for the read/issue stage: register groups, widths, R0 detection.
package gpr_read_issue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MLEN  = 512;
    localparam int unsigned NREG  = 32;
    localparam int unsigned NGRP  = 3;
    localparam int unsigned NSRC  = 3;
    localparam int unsigned GRP_W = 2;
    localparam int unsigned IDX_W = 5;

    localparam logic [GRP_W-1:0] REG_GROUP_R = 2'd0;
    localparam logic [GRP_W-1:0] REG_GROUP_F = 2'd1;
    localparam logic [GRP_W-1:0] REG_GROUP_M = 2'd2;

    localparam logic [IDX_W-1:0] zero5  = 5'd0;
    localparam logic [XLEN-1:0]  zero32 = 32'd0;

    typedef struct packed {
        logic             en;
        logic [GRP_W-1:0] group;
        logic [IDX_W-1:0] index;
    } reg_ref_t;

    // R0 is hardwired zero: never busy, never a hazard
    function automatic logic is_r0(input logic [GRP_W-1:0] g, input logic [IDX_W-1:0] i);
        return (g == REG_GROUP_R) && (i == zero5);
    endfunction

endpackage

// File: rtl/gpr_read_issue_sb_bitmap.sv
// Per-register busy scoreboard for the R/F/M groups; set wins over clear, clear_all wins over both.
module gpr_read_issue_sb_bitmap
    import gpr_read_issue_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             set_en,
    input  logic [GRP_W-1:0]                 set_group,
    input  logic [IDX_W-1:0]                 set_index,
    input  logic                             clr_en,
    input  logic [GRP_W-1:0]                 clr_group,
    input  logic [IDX_W-1:0]                 clr_index,
    input  logic                             clear_all,
    input  logic [NSRC-1:0][GRP_W-1:0]       lk_group,
    input  logic [NSRC-1:0][IDX_W-1:0]       lk_index,
    output logic [NSRC-1:0]                  lk_busy_c,
    input  logic [GRP_W-1:0]                 rd_group,
    input  logic [IDX_W-1:0]                 rd_index,
    output logic                             rd_busy_c
);

    logic [NGRP-1:0][NREG-1:0] busy_q;
    logic [NGRP-1:0][NREG-1:0] busy_d;

    // Lookups see the registered state; the WB bypass is applied by the caller
    always_comb begin
        lk_busy_c = '0;
        for (int unsigned n = 0; n < NSRC; n++) begin
            if (lk_group[n] < GRP_W'(NGRP)) begin
                lk_busy_c[n] = busy_q[lk_group[n]][lk_index[n]];
            end
        end
        rd_busy_c = 1'b0;
        if (rd_group < GRP_W'(NGRP)) begin
            rd_busy_c = busy_q[rd_group][rd_index];
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_group < GRP_W'(NGRP))) begin
            busy_d[clr_group][clr_index] = 1'b0;
        end
        if (set_en && (set_group < GRP_W'(NGRP)) && !is_r0(set_group, set_index)) begin
            busy_d[set_group][set_index] = 1'b1;
        end
        if (clear_all) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/gpr_read_issue.sv
// Read/issue stage: scoreboard hazard check, operand read with WB bypass, 1-entry slot to EX.
module gpr_read_issue
    import gpr_read_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_valid,
    output logic              ready,
    input  logic              rs1_en,
    input  logic [GRP_W-1:0]  rs1_group,
    input  logic [IDX_W-1:0]  rs1_index,
    input  logic              rs2_en,
    input  logic [GRP_W-1:0]  rs2_group,
    input  logic [IDX_W-1:0]  rs2_index,
    input  logic              rs3_en,
    input  logic [GRP_W-1:0]  rs3_group,
    input  logic [IDX_W-1:0]  rs3_index,
    input  logic              rd_en,
    input  logic [GRP_W-1:0]  rd_group,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [GRP_W-1:0]  gpr_rs1_group,
    output logic [IDX_W-1:0]  gpr_rs1_index,
    output logic [GRP_W-1:0]  gpr_rs2_group,
    output logic [IDX_W-1:0]  gpr_rs2_index,
    output logic [GRP_W-1:0]  gpr_rs3_group,
    output logic [IDX_W-1:0]  gpr_rs3_index,
    input  logic [XLEN-1:0]   gpr_R_rs1,
    input  logic [XLEN-1:0]   gpr_F_rs1,
    input  logic [MLEN-1:0]   gpr_M_rs1,
    input  logic [XLEN-1:0]   gpr_R_rs2,
    input  logic [XLEN-1:0]   gpr_F_rs2,
    input  logic [MLEN-1:0]   gpr_M_rs2,
    input  logic [XLEN-1:0]   gpr_R_rs3,
    input  logic [XLEN-1:0]   gpr_F_rs3,
    input  logic [MLEN-1:0]   gpr_M_rs3,
    input  logic              wb_we,
    input  logic [GRP_W-1:0]  wb_group,
    input  logic [IDX_W-1:0]  wb_index,
    input  logic [XLEN-1:0]   wb_R,
    input  logic [XLEN-1:0]   wb_F,
    input  logic [MLEN-1:0]   wb_M,
    input  logic              sb_clear_all,
    output logic              valid,
    input  logic              EX_ready,
    output logic [MLEN-1:0]   op1,
    output logic [MLEN-1:0]   op2,
    output logic [MLEN-1:0]   op3,
    output logic              ex_rd_en,
    output logic [GRP_W-1:0]  ex_rd_group,
    output logic [IDX_W-1:0]  ex_rd_index
);

    logic [NSRC-1:0]             rs_en;
    logic [NSRC-1:0][GRP_W-1:0]  rs_group;
    logic [NSRC-1:0][IDX_W-1:0]  rs_index;
    logic [NSRC-1:0][XLEN-1:0]   gpr_r;
    logic [NSRC-1:0][XLEN-1:0]   gpr_f;
    logic [NSRC-1:0][MLEN-1:0]   gpr_m;

    logic [NSRC-1:0]             lk_busy;
    logic                        rd_busy;
    logic [NSRC-1:0]             wb_src;
    logic [NSRC-1:0]             busy_src;
    logic [NSRC-1:0]             slot_raw;
    logic [NSRC-1:0][MLEN-1:0]   cap;
    logic                        rd_wb;
    logic                        waw;
    logic                        hazard;
    logic                        accept;
    logic                        issue_set;

    assign rs_en    = {rs3_en, rs2_en, rs1_en};
    assign rs_group = {rs3_group, rs2_group, rs1_group};
    assign rs_index = {rs3_index, rs2_index, rs1_index};
    assign gpr_r    = {gpr_R_rs3, gpr_R_rs2, gpr_R_rs1};
    assign gpr_f    = {gpr_F_rs3, gpr_F_rs2, gpr_F_rs1};
    assign gpr_m    = {gpr_M_rs3, gpr_M_rs2, gpr_M_rs1};

    assign gpr_rs1_group = rs1_group;
    assign gpr_rs1_index = rs1_index;
    assign gpr_rs2_group = rs2_group;
    assign gpr_rs2_index = rs2_index;
    assign gpr_rs3_group = rs3_group;
    assign gpr_rs3_index = rs3_index;

    gpr_read_issue_sb_bitmap u_sb_bitmap (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_set),
        .set_group (ex_rd_group),
        .set_index (ex_rd_index),
        .clr_en    (wb_we),
        .clr_group (wb_group),
        .clr_index (wb_index),
        .clear_all (sb_clear_all),
        .lk_group  (rs_group),
        .lk_index  (rs_index),
        .lk_busy_c (lk_busy),
        .rd_group  (rd_group),
        .rd_index  (rd_index),
        .rd_busy_c (rd_busy)
    );

    // Per-source hazard terms and operand capture mux (R0 -> zero, WB bypass, then Gpr data)
    always_comb begin
        wb_src   = '0;
        busy_src = '0;
        slot_raw = '0;
        cap      = '0;
        for (int unsigned n = 0; n < NSRC; n++) begin
            wb_src[n]   = wb_we && (wb_group == rs_group[n]) && (wb_index == rs_index[n]);
            busy_src[n] = rs_en[n] && lk_busy[n] && !wb_src[n];
            slot_raw[n] = valid && ex_rd_en && rs_en[n] && (ex_rd_group == rs_group[n])
                          && (ex_rd_index == rs_index[n]) && !is_r0(rs_group[n], rs_index[n]);
            if (!rs_en[n] || is_r0(rs_group[n], rs_index[n])) begin
                cap[n] = MLEN'(zero32);
            end else if (wb_src[n]) begin
                case (rs_group[n])
                    REG_GROUP_R: cap[n] = MLEN'(wb_R);
                    REG_GROUP_F: cap[n] = MLEN'(wb_F);
                    REG_GROUP_M: cap[n] = wb_M;
                    default:     cap[n] = '0;
                endcase
            end else begin
                case (rs_group[n])
                    REG_GROUP_R: cap[n] = MLEN'(gpr_r[n]);
                    REG_GROUP_F: cap[n] = MLEN'(gpr_f[n]);
                    REG_GROUP_M: cap[n] = gpr_m[n];
                    default:     cap[n] = '0;
                endcase
            end
        end
    end

    assign rd_wb     = wb_we && (wb_group == rd_group) && (wb_index == rd_index);
    assign waw       = rd_en && rd_busy && !rd_wb && !is_r0(rd_group, rd_index);
    assign hazard    = (|busy_src) || (|slot_raw) || waw;
    assign ready     = (!valid || EX_ready) && !hazard && !sb_clear_all;
    assign accept    = ID_valid && ready;
    assign issue_set = valid && EX_ready && ex_rd_en;

    // Output slot; accept already implies the slot is empty or draining this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= 1'b0;
            op1         <= '0;
            op2         <= '0;
            op3         <= '0;
            ex_rd_en    <= 1'b0;
            ex_rd_group <= '0;
            ex_rd_index <= '0;
        end else if (sb_clear_all) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid       <= 1'b1;
            op1         <= cap[0];
            op2         <= cap[1];
            op3         <= cap[2];
            ex_rd_en    <= rd_en;
            ex_rd_group <= rd_group;
            ex_rd_index <= rd_index;
        end else if (EX_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpr_read_issue.sv
// Scoreboard bench for gpr_read_issue: expected slot contents queued at accept, checked while valid.
module tb_gpr_read_issue;
    import gpr_read_issue_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ID_valid;
    logic              ready;
    logic              rs1_en, rs2_en, rs3_en, rd_en;
    logic [GRP_W-1:0]  rs1_group, rs2_group, rs3_group, rd_group;
    logic [IDX_W-1:0]  rs1_index, rs2_index, rs3_index, rd_index;
    logic [GRP_W-1:0]  gpr_rs1_group, gpr_rs2_group, gpr_rs3_group;
    logic [IDX_W-1:0]  gpr_rs1_index, gpr_rs2_index, gpr_rs3_index;
    logic [XLEN-1:0]   gpr_R_rs1, gpr_R_rs2, gpr_R_rs3;
    logic [XLEN-1:0]   gpr_F_rs1, gpr_F_rs2, gpr_F_rs3;
    logic [MLEN-1:0]   gpr_M_rs1, gpr_M_rs2, gpr_M_rs3;
    logic              wb_we;
    logic [GRP_W-1:0]  wb_group;
    logic [IDX_W-1:0]  wb_index;
    logic [XLEN-1:0]   wb_R, wb_F;
    logic [MLEN-1:0]   wb_M;
    logic              sb_clear_all;
    logic              valid;
    logic              EX_ready;
    logic [MLEN-1:0]   op1, op2, op3;
    logic              ex_rd_en;
    logic [GRP_W-1:0]  ex_rd_group;
    logic [IDX_W-1:0]  ex_rd_index;

    typedef struct packed {
        logic [MLEN-1:0]  op1;
        logic [MLEN-1:0]  op2;
        logic [MLEN-1:0]  op3;
        logic             rd_en;
        logic [GRP_W-1:0] rd_group;
        logic [IDX_W-1:0] rd_index;
    } exp_t;

    exp_t            sb_q[$];
    int              checks   = 0;
    int              failures = 0;
    logic [XLEN-1:0] r_mem [NREG];
    logic [XLEN-1:0] f_mem [NREG];
    logic [MLEN-1:0] m_mem [NREG];

    localparam reg_ref_t NONE = '0;

    gpr_read_issue dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ready(ready),
        .rs1_en(rs1_en), .rs1_group(rs1_group), .rs1_index(rs1_index),
        .rs2_en(rs2_en), .rs2_group(rs2_group), .rs2_index(rs2_index),
        .rs3_en(rs3_en), .rs3_group(rs3_group), .rs3_index(rs3_index),
        .rd_en(rd_en), .rd_group(rd_group), .rd_index(rd_index),
        .gpr_rs1_group(gpr_rs1_group), .gpr_rs1_index(gpr_rs1_index),
        .gpr_rs2_group(gpr_rs2_group), .gpr_rs2_index(gpr_rs2_index),
        .gpr_rs3_group(gpr_rs3_group), .gpr_rs3_index(gpr_rs3_index),
        .gpr_R_rs1(gpr_R_rs1), .gpr_F_rs1(gpr_F_rs1), .gpr_M_rs1(gpr_M_rs1),
        .gpr_R_rs2(gpr_R_rs2), .gpr_F_rs2(gpr_F_rs2), .gpr_M_rs2(gpr_M_rs2),
        .gpr_R_rs3(gpr_R_rs3), .gpr_F_rs3(gpr_F_rs3), .gpr_M_rs3(gpr_M_rs3),
        .wb_we(wb_we), .wb_group(wb_group), .wb_index(wb_index),
        .wb_R(wb_R), .wb_F(wb_F), .wb_M(wb_M),
        .sb_clear_all(sb_clear_all), .valid(valid), .EX_ready(EX_ready),
        .op1(op1), .op2(op2), .op3(op3),
        .ex_rd_en(ex_rd_en), .ex_rd_group(ex_rd_group), .ex_rd_index(ex_rd_index)
    );

    always #5 clk = ~clk;

    // Register file model answering the read ports from the bench's own source fields
    assign gpr_R_rs1 = r_mem[rs1_index];
    assign gpr_F_rs1 = f_mem[rs1_index];
    assign gpr_M_rs1 = m_mem[rs1_index];
    assign gpr_R_rs2 = r_mem[rs2_index];
    assign gpr_F_rs2 = f_mem[rs2_index];
    assign gpr_M_rs2 = m_mem[rs2_index];
    assign gpr_R_rs3 = r_mem[rs3_index];
    assign gpr_F_rs3 = f_mem[rs3_index];
    assign gpr_M_rs3 = m_mem[rs3_index];

    task automatic check_val(input string tag, input logic [MLEN-1:0] got, input logic [MLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MLEN-1:0] exp_op(input logic en, input logic [GRP_W-1:0] g,
                                               input logic [IDX_W-1:0] i);
        if (!en) return '0;
        if (g == REG_GROUP_R && i == 5'd0) return '0;
        if (wb_we && wb_group == g && wb_index == i) begin
            case (g)
                REG_GROUP_R: return MLEN'(wb_R);
                REG_GROUP_F: return MLEN'(wb_F);
                REG_GROUP_M: return wb_M;
                default:     return '0;
            endcase
        end
        case (g)
            REG_GROUP_R: return MLEN'(r_mem[i]);
            REG_GROUP_F: return MLEN'(f_mem[i]);
            REG_GROUP_M: return m_mem[i];
            default:     return '0;
        endcase
    endfunction

    function automatic reg_ref_t mk(input logic [GRP_W-1:0] g, input logic [IDX_W-1:0] i);
        reg_ref_t r;
        r.en = 1'b1; r.group = g; r.index = i;
        return r;
    endfunction

    task automatic issue_instr(input reg_ref_t s1, input reg_ref_t s2, input reg_ref_t s3, input reg_ref_t d);
        ID_valid = 1'b1;
        {rs1_en, rs1_group, rs1_index} = s1;
        {rs2_en, rs2_group, rs2_index} = s2;
        {rs3_en, rs3_group, rs3_index} = s3;
        {rd_en, rd_group, rd_index}    = d;
    endtask

    task automatic idle();
        issue_instr(NONE, NONE, NONE, NONE);
        ID_valid = 1'b0;
    endtask

    task automatic set_wb(input logic [GRP_W-1:0] g, input logic [IDX_W-1:0] i, input logic [MLEN-1:0] d);
        wb_we = 1'b1; wb_group = g; wb_index = i;
        wb_R = d[XLEN-1:0]; wb_F = d[XLEN-1:0]; wb_M = d;
    endtask

    // One cycle: compare the slot against the queue head, check ready, queue an accept, commit WB
    task automatic tick(input logic exp_ready, input string tag);
        exp_t e;
        @(negedge clk);
        if (valid) begin
            if (sb_q.size() == 0) begin
                check_val({tag, "_spurious_valid"}, MLEN'(valid), '0);
            end else begin
                e = sb_q[0];
                check_val({tag, "_op1"}, op1, e.op1);
                check_val({tag, "_op2"}, op2, e.op2);
                check_val({tag, "_op3"}, op3, e.op3);
                check_val({tag, "_rd"}, MLEN'({ex_rd_en, ex_rd_group, ex_rd_index}),
                          MLEN'({e.rd_en, e.rd_group, e.rd_index}));
                if (EX_ready) e = sb_q.pop_front();
            end
        end
        check_val({tag, "_ready"}, MLEN'(ready), MLEN'(exp_ready));
        if (ID_valid && exp_ready) begin
            e.op1      = exp_op(rs1_en, rs1_group, rs1_index);
            e.op2      = exp_op(rs2_en, rs2_group, rs2_index);
            e.op3      = exp_op(rs3_en, rs3_group, rs3_index);
            e.rd_en    = rd_en;
            e.rd_group = rd_group;
            e.rd_index = rd_index;
            sb_q.push_back(e);
        end
        if (sb_clear_all) sb_q.delete();
        @(posedge clk);
        if (wb_we) begin
            case (wb_group)
                REG_GROUP_R: if (wb_index != 5'd0) r_mem[wb_index] = wb_R;
                REG_GROUP_F: f_mem[wb_index] = wb_F;
                REG_GROUP_M: m_mem[wb_index] = wb_M;
                default: ;
            endcase
        end
        #1;
        wb_we        = 1'b0;
        sb_clear_all = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < int'(NREG); i++) begin
            r_mem[i] = 32'h100 + 32'(i);
            f_mem[i] = 32'h200 + 32'(i);
            m_mem[i] = {16{32'h300 + 32'(i)}};
        end
        r_mem[0] = 32'hFFFF;
        r_mem[5] = 32'h11;
        r_mem[6] = 32'h22;
        rst = 1'b0;
        idle();
        wb_we = 1'b0; wb_group = '0; wb_index = '0; wb_R = '0; wb_F = '0; wb_M = '0;
        sb_clear_all = 1'b0;
        EX_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", MLEN'(valid), '0);
        check_val("rst_op1", op1, '0);
        check_val("rst_exrd", MLEN'({ex_rd_en, ex_rd_group, ex_rd_index}), '0);
        rst = 1'b1;
        tick(1'b1, "rst_ready");

        // Basic read of R5/R6
        issue_instr(mk(REG_GROUP_R, 5), mk(REG_GROUP_R, 6), NONE, NONE);
        #1 check_val("gpr_port1", MLEN'({gpr_rs1_group, gpr_rs1_index}), MLEN'({REG_GROUP_R, 5'd5}));
        tick(1'b1, "t1_acc");
        idle();
        tick(1'b1, "t1_out");

        // RAW on R3: slot hazard, then busy, then released by WB bypass
        issue_instr(NONE, NONE, NONE, mk(REG_GROUP_R, 3));
        tick(1'b1, "t2_wr");
        issue_instr(mk(REG_GROUP_R, 3), NONE, NONE, NONE);
        tick(1'b0, "t2_slot_raw");
        tick(1'b0, "t2_busy");
        set_wb(REG_GROUP_R, 3, MLEN'(32'hAB));
        tick(1'b1, "t2_bypass");
        idle();
        tick(1'b1, "t2_out");

        // R0 reads zero and never stalls
        issue_instr(mk(REG_GROUP_R, 0), NONE, NONE, mk(REG_GROUP_R, 0));
        tick(1'b1, "t3_a");
        issue_instr(mk(REG_GROUP_R, 0), mk(REG_GROUP_R, 0), NONE, mk(REG_GROUP_R, 0));
        tick(1'b1, "t3_b");
        tick(1'b1, "t3_c");
        idle();
        tick(1'b1, "t3_out");

        // F7: issue-set and WB-clear in the same cycle leaves it busy
        issue_instr(NONE, NONE, NONE, mk(REG_GROUP_F, 7));
        tick(1'b1, "t4_w1");
        idle();
        tick(1'b1, "t4_w1_issue");
        issue_instr(NONE, NONE, NONE, mk(REG_GROUP_F, 7));
        set_wb(REG_GROUP_F, 7, MLEN'(32'h777));
        tick(1'b1, "t4_w2");
        idle();
        set_wb(REG_GROUP_F, 7, MLEN'(32'h778));
        tick(1'b1, "t4_set_wins");
        issue_instr(mk(REG_GROUP_F, 7), NONE, NONE, NONE);
        tick(1'b0, "t4_still_busy");
        set_wb(REG_GROUP_F, 7, MLEN'(32'h779));
        tick(1'b1, "t4_rd");
        idle();
        tick(1'b1, "t4_out");

        // Backpressure: slot holds while EX stalls
        issue_instr(mk(REG_GROUP_R, 10), mk(REG_GROUP_F, 4), mk(REG_GROUP_M, 9), mk(REG_GROUP_M, 1));
        tick(1'b1, "t5_acc");
        issue_instr(mk(REG_GROUP_R, 12), NONE, NONE, NONE);
        EX_ready = 1'b0;
        repeat (3) tick(1'b0, "t5_hold");
        EX_ready = 1'b1;
        tick(1'b1, "t5_release");
        idle();
        tick(1'b1, "t5_out");

        // Flush with M2 busy and a held slot
        issue_instr(NONE, NONE, NONE, mk(REG_GROUP_M, 2));
        tick(1'b1, "t6_w");
        idle();
        tick(1'b1, "t6_w_issue");
        issue_instr(NONE, NONE, NONE, mk(REG_GROUP_M, 5));
        tick(1'b1, "t6_f");
        idle();
        EX_ready = 1'b0;
        tick(1'b0, "t6_hold");
        sb_clear_all = 1'b1;
        issue_instr(mk(REG_GROUP_M, 2), NONE, NONE, NONE);
        tick(1'b0, "t6_clear");
        EX_ready = 1'b1;
        check_val("t6_flush_valid", MLEN'(valid), '0);
        tick(1'b1, "t6_reader");
        idle();
        tick(1'b1, "t6_out");

        // Back-to-back random readers with random WB traffic (bypass on odd steps)
        for (int k = 0; k < 8; k++) begin
            reg_ref_t s [3];
            for (int n = 0; n < 3; n++) begin
                s[n] = mk(GRP_W'($urandom_range(0, 2)), IDX_W'($urandom_range(0, 31)));
                s[n].en = 1'($urandom_range(0, 1));
            end
            issue_instr(s[0], s[1], s[2], NONE);
            if (k % 2 == 1) set_wb(s[0].group, s[0].index, {16{$urandom()}});
            else            set_wb(GRP_W'($urandom_range(0, 2)), IDX_W'($urandom_range(0, 31)), {16{$urandom()}});
            tick(1'b1, "t7_b2b");
        end
        idle();
        tick(1'b1, "t7_out");

        // Asynchronous reset drops the slot immediately
        issue_instr(mk(REG_GROUP_R, 7), NONE, NONE, NONE);
        tick(1'b1, "t8_acc");
        rst = 1'b0;
        #1;
        check_val("t8_async_valid", MLEN'(valid), '0);
        check_val("t8_async_op1", op1, '0);
        sb_q.delete();
        rst = 1'b1;
        idle();
        tick(1'b1, "t8_after");

        for (int c = 0; c < 5 && sb_q.size() > 0; c++) tick(1'b1, "drain");
        check_val("queue_drained", MLEN'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
